// File: rtl/stutter_gen.sv
// ----------------------------------------------------------------------------
// stutter_gen
// Programmable tick generator. Counts enabled clock cycles from 0 up to a
// captured terminal value and emits a one-cycle tick on each wrap. It can run
// periodically or as a one-shot. A second-stage counter counts ticks, and cy
// pulses together with the tick that wraps that counter.
//
// Parameters
//   WIDTH     width of the cycle counter and of period
//   CNT_W     width of the tick counter
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   en        count enable (count holds while low in RUN)
//   start     launch request, honoured only in IDLE
//   stop      synchronous abort to IDLE, wins over start and wrap
//   mode      0 = periodic, 1 = one-shot, captured when start is accepted
//   period    terminal count P; tick interval is P+1 enabled cycles
//   tick      registered one-cycle pulse at each wrap
//   cy        registered pulse with the tick that wraps tick_cnt
//   busy      high while in RUN
//   count     current cycle count
//   tick_cnt  ticks since start, modulo 2^CNT_W
// ----------------------------------------------------------------------------
module stutter_gen #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             tick,
  output logic             cy,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [CNT_W-1:0] tick_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_count;
  logic [WIDTH-1:0]   w_count_nxt;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic [CNT_W-1:0]   w_tick_cnt_nxt;
  logic               r_tick;
  logic               w_tick_nxt;
  logic               r_cy;
  logic               w_cy_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic [WIDTH-1:0]   r_period_q;
  logic [WIDTH-1:0]   w_period_q_nxt;
  logic               r_mode_q;
  logic               w_mode_q_nxt;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
      r_cy       <= 1'b0;
      r_busy     <= 1'b0;
      r_period_q <= '1;
      r_mode_q   <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_tick     <= w_tick_nxt;
      r_cy       <= w_cy_nxt;
      r_busy     <= w_busy_nxt;
      r_period_q <= w_period_q_nxt;
      r_mode_q   <= w_mode_q_nxt;
    end
  end

  // Next-state and next-value logic. tick/cy default low so they only
  // survive on a wrap edge; stop is checked first so it overrides start/wrap.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_tick_cnt_nxt = r_tick_cnt;
    w_tick_nxt     = 1'b0;
    w_cy_nxt       = 1'b0;
    w_period_q_nxt = r_period_q;
    w_mode_q_nxt   = r_mode_q;

    if (stop) begin
      w_state_nxt    = ST_IDLE;
      w_count_nxt    = '0;
      w_tick_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_count_nxt    = '0;
          w_tick_cnt_nxt = '0;
          // Track period continuously so the value present at start is used.
          w_period_q_nxt = period;
          if (start) begin
            w_state_nxt  = ST_RUN;
            w_mode_q_nxt = mode;
          end else begin
            w_state_nxt  = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (en) begin
            if (r_count != r_period_q) begin
              w_count_nxt = r_count + WIDTH'(1);
            end else begin
              w_count_nxt    = '0;
              w_tick_nxt     = 1'b1;
              w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
              w_cy_nxt       = &r_tick_cnt;
              // New period only takes effect at a wrap, keeping intervals clean.
              w_period_q_nxt = period;
              if (r_mode_q) begin
                w_state_nxt = ST_IDLE;
              end else begin
                w_state_nxt = ST_RUN;
              end
            end
          end else begin
            w_count_nxt = r_count;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_count_nxt    = '0;
          w_tick_cnt_nxt = '0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == ST_RUN);
  end

  assign tick     = r_tick;
  assign cy       = r_cy;
  assign busy     = r_busy;
  assign count    = r_count;
  assign tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_stutter_gen.sv
// ----------------------------------------------------------------------------
// tb_stutter_gen
// Directed bench for stutter_gen with WIDTH=4, CNT_W=2. Stimulus pushes the
// expected tick events (edge number, tick_cnt, cy, busy) into a scoreboard
// queue; a monitor pops one entry for every tick the DUT presents.
// ----------------------------------------------------------------------------
module tb_stutter_gen;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic             tick;
  logic             cy;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic [CNT_W-1:0] tick_cnt;

  typedef struct packed {
    logic [31:0]      edge_no;
    logic [CNT_W-1:0] tcnt;
    logic             cy;
    logic             busy;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   edge_n = 0;

  stutter_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
    .tick     (tick),
    .cy       (cy),
    .busy     (busy),
    .count    (count),
    .tick_cnt (tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push(input int e, input int t, input logic c, input logic b);
    exp_t x;
    x.edge_no = e;
    x.tcnt    = t[CNT_W-1:0];
    x.cy      = c;
    x.busy    = b;
    sb.push_back(x);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (edge_n < target) @(negedge clk);
  endtask

  task automatic do_start(output int k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = edge_n;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   k;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    mode   = 1'b0;
    period = 4'd3;

    // Monitor: every tick must match the head of the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && tick) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tick: got tick=1 expected none (edge %0d)", edge_n);
          end else begin
            e = sb.pop_front();
            if (edge_n != int'(e.edge_no) || tick_cnt !== e.tcnt || cy !== e.cy ||
                busy !== e.busy || count !== 4'd0) begin
              errors++;
              $display("FAIL tick_event: got edge=%0d tick_cnt=%0d cy=%0d busy=%0d count=%0d expected edge=%0d tick_cnt=%0d cy=%0d busy=%0d count=0",
                       edge_n, tick_cnt, cy, busy, count, e.edge_no, e.tcnt, e.cy, e.busy);
            end
          end
        end else if (rst_n && cy) begin
          checks++;
          errors++;
          $display("FAIL cy_without_tick: got cy=1 expected 0 (edge %0d)", edge_n);
        end
      end
    join_none

    // Reset state.
    cycles(2);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tick_cnt", 32'(tick_cnt), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Periodic P=3: ticks at k+4, k+8, k+12, k+16; cy with the 4th.
    period = 4'd3;
    do_start(k);
    chk("p3_busy_after_start", 32'(busy), 32'd1);
    chk("p3_count_after_start", 32'(count), 32'd0);
    push(k + 4, 1, 1'b0, 1'b1);
    push(k + 8, 2, 1'b0, 1'b1);
    push(k + 12, 3, 1'b0, 1'b1);
    push(k + 16, 0, 1'b1, 1'b1);
    wait_until(k + 17);
    do_stop();
    chk("p3_stop_busy", 32'(busy), 32'd0);
    chk("p3_stop_count", 32'(count), 32'd0);
    chk("p3_stop_tick_cnt", 32'(tick_cnt), 32'd0);
    cycles(1);
    chk("p3_drain", 32'(sb.size()), 32'd0);

    // One-shot P=2: single tick on k+3, busy falls on that edge.
    period = 4'd2;
    mode   = 1'b1;
    do_start(k);
    mode   = 1'b0;
    push(k + 3, 1, 1'b0, 1'b0);
    wait_until(k + 2);
    chk("os_busy_before", 32'(busy), 32'd1);
    chk("os_count_before", 32'(count), 32'd2);
    wait_until(k + 3);
    cycles(20);
    chk("os_busy_after", 32'(busy), 32'd0);
    chk("os_count_after", 32'(count), 32'd0);
    chk("os_drain", 32'(sb.size()), 32'd0);

    // Enable gap: en low for 2 edges at count=1 stretches the interval to 6.
    period = 4'd3;
    do_start(k);
    push(k + 6, 1, 1'b0, 1'b1);
    push(k + 10, 2, 1'b0, 1'b1);
    push(k + 14, 3, 1'b0, 1'b1);
    wait_until(k + 1);
    chk("en_count_pre", 32'(count), 32'd1);
    en = 1'b0;
    cycles(1);
    chk("en_count_hold1", 32'(count), 32'd1);
    cycles(1);
    chk("en_count_hold2", 32'(count), 32'd1);
    en = 1'b1;
    wait_until(k + 15);
    do_stop();
    cycles(1);
    chk("en_drain", 32'(sb.size()), 32'd0);

    // Period change mid-interval applies only after the current wrap.
    period = 4'd3;
    do_start(k);
    push(k + 4, 1, 1'b0, 1'b1);
    push(k + 6, 2, 1'b0, 1'b1);
    push(k + 8, 3, 1'b0, 1'b1);
    push(k + 10, 0, 1'b1, 1'b1);
    wait_until(k + 2);
    chk("pc_count_at_change", 32'(count), 32'd2);
    period = 4'd1;
    wait_until(k + 10);
    do_stop();
    period = 4'd3;
    cycles(1);
    chk("pc_drain", 32'(sb.size()), 32'd0);

    // P=0: tick every enabled edge; stop clears; start+stop in IDLE stays IDLE.
    period = 4'd0;
    do_start(k);
    push(k + 1, 1, 1'b0, 1'b1);
    push(k + 2, 2, 1'b0, 1'b1);
    push(k + 3, 3, 1'b0, 1'b1);
    push(k + 4, 0, 1'b1, 1'b1);
    push(k + 5, 1, 1'b0, 1'b1);
    wait_until(k + 5);
    do_stop();
    chk("p0_stop_tick", 32'(tick), 32'd0);
    chk("p0_stop_busy", 32'(busy), 32'd0);
    chk("p0_stop_count", 32'(count), 32'd0);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("p0_start_stop_busy", 32'(busy), 32'd0);
    cycles(3);
    chk("p0_idle_busy", 32'(busy), 32'd0);
    chk("p0_drain", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-count, then restart; a start in RUN is ignored.
    period = 4'd3;
    do_start(k);
    push(k + 4, 1, 1'b0, 1'b1);
    wait_until(k + 6);
    chk("rr_count_before", 32'(count), 32'd2);
    chk("rr_tick_cnt_before", 32'(tick_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_async_busy", 32'(busy), 32'd0);
    chk("rr_async_count", 32'(count), 32'd0);
    chk("rr_async_tick_cnt", 32'(tick_cnt), 32'd0);
    chk("rr_async_tick_cy", 32'({tick, cy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(10);
    chk("rr_idle_busy", 32'(busy), 32'd0);
    do_start(k);
    push(k + 4, 1, 1'b0, 1'b1);
    push(k + 8, 2, 1'b0, 1'b1);
    wait_until(k + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rr_run_start_ignored", 32'(count), 32'd2);
    wait_until(k + 8);
    do_stop();
    cycles(2);
    chk("rr_drain", 32'(sb.size()), 32'd0);

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
